// File: rtl/param_bus_datapath.sv
// Single-bus processor datapath: register file, HI/LO, Y, Z, PC, IR, MAR,
// MDR and I/O ports around one shared bus and an ALU. The control unit
// drives one micro-op per transaction. Memory micro-ops stall until the
// memory acks. MUL/DIV iterate for DATA_W cycles.
//
// Handshake: a micro-op is consumed on a rising edge where uop_valid and
// uop_ready are both high. uop_ready is a function of state only and is
// high exactly in IDLE. While uop_ready is low the control unit holds the
// micro-op stable, and the datapath ignores it.
module param_bus_datapath #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 9,
  parameter int IMM_W    = 19,
  localparam int RIDX_W  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              uop_valid,
  output logic              uop_ready,
  input  logic [3:0]        uop_src,
  input  logic [RIDX_W-1:0] uop_rsrc,
  input  logic [RIDX_W-1:0] uop_rdst,
  input  logic [8:0]        uop_dst,
  input  logic              uop_zin,
  input  logic [3:0]        uop_alu,
  input  logic [1:0]        uop_mem,
  input  logic              ba_mode,
  input  logic [DATA_W-1:0] inport_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] outport_data,
  output logic [DATA_W-1:0] bus_dbg,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  localparam int SH_W   = $clog2(DATA_W);
  localparam int CNT_W  = $clog2(DATA_W);
  // IR is only ever observed through its immediate field, so it is kept at
  // that width (clamped to DATA_W for narrow configurations).
  localparam int IMM_E  = (IMM_W < DATA_W) ? IMM_W : DATA_W;
  localparam int IMM_SH = DATA_W - IMM_E;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MEM    = 2'd1,
    S_MULDIV = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Architectural registers
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] hi, lo, y, zhi, zlo, pc, mdr, inport, outport;
  logic [IMM_E-1:0]  ir;
  logic [ADDR_W-1:0] mar;
  logic              mem_wr;

  // Iterative MUL/DIV working state
  logic [DATA_W-1:0] md_a;      // |bus|: multiplicand or divisor magnitude
  logic [DATA_W-1:0] md_hi;     // partial product high / partial remainder
  logic [DATA_W-1:0] md_lo;     // multiplier shifting out / quotient shifting in
  logic [DATA_W-1:0] md_y;      // original Y for the divide-by-zero result
  logic [CNT_W-1:0]  md_cnt;
  logic              md_div, md_neg_q, md_neg_r, md_zero;

  logic [DATA_W-1:0] bus, imm, alu_res;
  logic              accept, is_mem, is_md, md_last;

  assign accept  = uop_valid && uop_ready;
  assign is_mem  = (uop_mem == 2'b01) || (uop_mem == 2'b10);
  assign is_md   = uop_zin && !is_mem && ((uop_alu == 4'd12) || (uop_alu == 4'd13));
  assign md_last = (md_cnt == CNT_W'(DATA_W - 1));

  // Sign-extend the IR immediate field to the datapath width
  always_comb begin
    logic signed [DATA_W-1:0] imm_pad;
    imm_pad = DATA_W'(ir) << IMM_SH;
    imm     = DATA_W'(imm_pad >>> IMM_SH);
  end

  // Shared bus source mux
  always_comb begin
    bus = '0;
    case (uop_src)
      4'd0:    bus = (ba_mode && (uop_rsrc == '0)) ? '0 : regs[uop_rsrc];
      4'd1:    bus = hi;
      4'd2:    bus = lo;
      4'd3:    bus = zhi;
      4'd4:    bus = zlo;
      4'd5:    bus = pc;
      4'd6:    bus = mdr;
      4'd7:    bus = inport;
      4'd8:    bus = imm;
      default: bus = '0;
    endcase
  end

  // Single-cycle ALU; shifts and rotates act on Y by the low bus bits
  always_comb begin
    logic [SH_W-1:0]     shamt, rot_amt;
    logic [31:0]         sh32;
    logic [2*DATA_W-1:0] yy, ror_full, rol_full;
    shamt    = bus[SH_W-1:0];
    sh32     = 32'(shamt);
    // Rotation wraps modulo DATA_W so non-power-of-two widths stay correct
    rot_amt  = SH_W'(sh32 % 32'(DATA_W));
    yy       = {y, y};
    ror_full = yy >> rot_amt;
    rol_full = yy << rot_amt;
    alu_res  = bus;
    case (uop_alu)
      4'd0:    alu_res = y + bus;
      4'd1:    alu_res = y - bus;
      4'd2:    alu_res = y & bus;
      4'd3:    alu_res = y | bus;
      4'd4:    alu_res = y >> shamt;
      4'd5:    alu_res = DATA_W'($signed(y) >>> shamt);
      4'd6:    alu_res = y << shamt;
      4'd7:    alu_res = ror_full[DATA_W-1:0];
      4'd8:    alu_res = rol_full[2*DATA_W-1:DATA_W];
      4'd9:    alu_res = -bus;
      4'd10:   alu_res = ~bus;
      4'd11:   alu_res = bus + DATA_W'(1);
      default: alu_res = bus;
    endcase
  end

  // One MUL/DIV iteration plus sign fix-up of the finished result
  logic [DATA_W-1:0] step_hi, step_lo, fin_hi, fin_lo;
  always_comb begin
    logic [DATA_W:0]     sum, rs, diff;
    logic                ge;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   q_mag, r_mag;
    // shift-add multiply step on magnitudes
    sum  = {1'b0, md_hi} + ({1'b0, md_a} & {(DATA_W+1){md_lo[0]}});
    // restoring divide step on magnitudes
    rs   = {md_hi, md_lo[DATA_W-1]};
    diff = rs - {1'b0, md_a};
    ge   = !diff[DATA_W];
    if (md_div) begin
      step_hi = ge ? diff[DATA_W-1:0] : rs[DATA_W-1:0];
      step_lo = {md_lo[DATA_W-2:0], ge};
    end else begin
      step_hi = sum[DATA_W:1];
      step_lo = {sum[0], md_lo[DATA_W-1:1]};
    end
    q_mag = step_lo;
    r_mag = step_hi;
    prod  = {step_hi, step_lo};
    prod  = md_neg_q ? -prod : prod;
    if (!md_div) begin
      fin_hi = prod[2*DATA_W-1:DATA_W];
      fin_lo = prod[DATA_W-1:0];
    end else if (md_zero) begin
      fin_hi = md_y;
      fin_lo = '1;
    end else begin
      fin_hi = md_neg_r ? -r_mag : r_mag;
      fin_lo = md_neg_q ? -q_mag : q_mag;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept && is_mem)     state_nxt = S_MEM;
        else if (accept && is_md) state_nxt = S_MULDIV;
      end
      S_MEM:    if (mem_ack) state_nxt = S_IDLE;
      S_MULDIV: if (md_last) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // State-derived outputs
  always_comb begin
    uop_ready = (state == S_IDLE);
    busy      = (state != S_IDLE);
    mem_req   = (state == S_MEM);
    mem_we    = (state == S_MEM) && mem_wr;
    state_dbg = state;
  end

  assign mem_addr     = mar;
  assign mem_wdata    = mdr;
  assign outport_data = outport;
  assign bus_dbg      = bus;

  // Register loads, Z updates, memory read capture and MUL/DIV iteration
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      hi       <= '0;
      lo       <= '0;
      y        <= '0;
      zhi      <= '0;
      zlo      <= '0;
      pc       <= '0;
      ir       <= '0;
      mar      <= '0;
      mdr      <= '0;
      inport   <= '0;
      outport  <= '0;
      mem_wr   <= 1'b0;
      md_a     <= '0;
      md_hi    <= '0;
      md_lo    <= '0;
      md_y     <= '0;
      md_cnt   <= '0;
      md_div   <= 1'b0;
      md_neg_q <= 1'b0;
      md_neg_r <= 1'b0;
      md_zero  <= 1'b0;
    end else begin
      inport <= inport_data;
      if (accept && is_mem) begin
        mem_wr <= (uop_mem == 2'b10);
      end else if (accept) begin
        if (uop_dst[0]) regs[uop_rdst] <= bus;
        if (uop_dst[1]) y       <= bus;
        if (uop_dst[2]) hi      <= bus;
        if (uop_dst[3]) lo      <= bus;
        if (uop_dst[4]) pc      <= bus;
        if (uop_dst[5]) mar     <= bus[ADDR_W-1:0];
        if (uop_dst[6]) mdr     <= bus;
        if (uop_dst[7]) ir      <= bus[IMM_E-1:0];
        if (uop_dst[8]) outport <= bus;
        if (is_md) begin
          md_a     <= bus[DATA_W-1] ? -bus : bus;
          md_lo    <= y[DATA_W-1] ? -y : y;
          md_hi    <= '0;
          md_y     <= y;
          md_cnt   <= '0;
          md_div   <= (uop_alu == 4'd13);
          md_neg_q <= y[DATA_W-1] ^ bus[DATA_W-1];
          md_neg_r <= y[DATA_W-1];
          md_zero  <= (bus == '0);
        end else if (uop_zin) begin
          zlo <= alu_res;
          zhi <= '0;
        end
      end
      if (state == S_MEM && mem_ack && !mem_wr) mdr <= mem_rdata;
      if (state == S_MULDIV) begin
        md_hi  <= step_hi;
        md_lo  <= step_lo;
        md_cnt <= md_cnt + CNT_W'(1);
        if (md_last) begin
          zhi <= fin_hi;
          zlo <= fin_lo;
        end
      end
    end
  end

endmodule

// File: tb/tb_param_bus_datapath.sv
// Bench for param_bus_datapath at the default 32-bit / 16-register build:
// a table of ALU/MUL/DIV vectors plus hand sequences for register moves,
// memory stalls and reset during MUL.
module tb_param_bus_datapath;

  localparam int DATA_W = 32;
  localparam int NUM_REGS = 16;
  localparam int ADDR_W = 9;
  localparam int IMM_W = 19;

  localparam logic [3:0] SRC_REG = 4'd0, SRC_HI = 4'd1, SRC_LO = 4'd2, SRC_ZHI = 4'd3,
                         SRC_ZLO = 4'd4, SRC_PC = 4'd5, SRC_MDR = 4'd6, SRC_IN = 4'd7,
                         SRC_IMM = 4'd8, SRC_ZERO = 4'd15;
  localparam logic [8:0] DST_REG = 9'h001, DST_Y = 9'h002, DST_HI = 9'h004, DST_LO = 9'h008,
                         DST_PC = 9'h010, DST_MAR = 9'h020, DST_MDR = 9'h040, DST_IR = 9'h080,
                         DST_OUT = 9'h100;
  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR = 4'd3, A_SHR = 4'd4,
                         A_SHRA = 4'd5, A_SHL = 4'd6, A_ROR = 4'd7, A_ROL = 4'd8, A_NEG = 4'd9,
                         A_NOT = 4'd10, A_INC = 4'd11, A_MUL = 4'd12, A_DIV = 4'd13, A_PASS = 4'd14;

  logic              clk = 1'b0;
  logic              reset;
  logic              uop_valid, uop_ready;
  logic [3:0]        uop_src, uop_rsrc, uop_rdst, uop_alu;
  logic [8:0]        uop_dst;
  logic              uop_zin;
  logic [1:0]        uop_mem, state_dbg;
  logic              ba_mode;
  logic [DATA_W-1:0] inport_data, mem_wdata, mem_rdata, outport_data, bus_dbg;
  logic              mem_req, mem_we, mem_ack, busy;
  logic [ADDR_W-1:0] mem_addr;

  int errors = 0;
  int checks = 0;
  logic [DATA_W-1:0] exp_q[$];

  // Clock
  always #5 clk = ~clk;

  param_bus_datapath #(
    .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .IMM_W(IMM_W)
  ) dut (
    .clk(clk), .reset(reset), .uop_valid(uop_valid), .uop_ready(uop_ready),
    .uop_src(uop_src), .uop_rsrc(uop_rsrc), .uop_rdst(uop_rdst), .uop_dst(uop_dst),
    .uop_zin(uop_zin), .uop_alu(uop_alu), .uop_mem(uop_mem), .ba_mode(ba_mode),
    .inport_data(inport_data), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .outport_data(outport_data), .bus_dbg(bus_dbg), .busy(busy), .state_dbg(state_dbg)
  );

  typedef struct {
    logic [DATA_W-1:0] y;
    logic [DATA_W-1:0] b;
    logic [3:0]        alu;
    logic [DATA_W-1:0] exp_lo;
    logic [DATA_W-1:0] exp_hi;
  } vec_t;

  vec_t vecs[23];

  // Scoreboard compare
  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Read the combinational bus for a given source without issuing a micro-op
  task automatic peek(input logic [3:0] src, input logic [3:0] rsrc, output logic [DATA_W-1:0] v);
    uop_valid = 1'b0;
    uop_src   = src;
    uop_rsrc  = rsrc;
    #1;
    v = bus_dbg;
  endtask

  // Driver: present one micro-op and hold it until accepted (bounded)
  task automatic issue(input logic [3:0] src, input logic [3:0] rsrc, input logic [3:0] rdst,
                       input logic [8:0] dst, input logic zin, input logic [3:0] alu,
                       input logic [1:0] mem);
    int n;
    uop_src = src; uop_rsrc = rsrc; uop_rdst = rdst; uop_dst = dst;
    uop_zin = zin; uop_alu = alu; uop_mem = mem; uop_valid = 1'b1;
    n = 0;
    while (!uop_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!uop_ready) check("accept_timeout", 32'(uop_ready), 32'd1);
    else begin
      @(posedge clk); #1;
    end
    uop_valid = 1'b0;
  endtask

  // Wait for return to IDLE, counting cycles with uop_ready low (bounded)
  task automatic wait_idle(output int n);
    n = 0;
    while (!uop_ready && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
    if (!uop_ready) check("idle_timeout", 32'(uop_ready), 32'd1);
  endtask

  // Move a value through INPORT into the registers named by dst
  task automatic load_via_in(input logic [DATA_W-1:0] v, input logic [8:0] dst, input logic [3:0] rdst);
    inport_data = v;
    @(posedge clk); #1;
    issue(SRC_IN, 4'd0, rdst, dst, 1'b0, A_ADD, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] v;
    int n, req_cycles;
    logic addr_ok, early;

    vecs[0]  = '{32'hFFFFFFFD, 32'h00000007, A_MUL,  32'hFFFFFFEB, 32'hFFFFFFFF};
    vecs[1]  = '{32'h0000000C, 32'h00000005, A_SUB,  32'h00000007, 32'h00000000};
    vecs[2]  = '{32'h12345678, 32'h11111111, A_ADD,  32'h23456789, 32'h00000000};
    vecs[3]  = '{32'h00000000, 32'h00000001, A_SUB,  32'hFFFFFFFF, 32'h00000000};
    vecs[4]  = '{32'hF0F0F0F0, 32'hFF00FF00, A_AND,  32'hF000F000, 32'h00000000};
    vecs[5]  = '{32'hF0F0F0F0, 32'h0F000000, A_OR,   32'hFFF0F0F0, 32'h00000000};
    vecs[6]  = '{32'h80000000, 32'h00000004, A_SHR,  32'h08000000, 32'h00000000};
    vecs[7]  = '{32'h80000000, 32'h00000004, A_SHRA, 32'hF8000000, 32'h00000000};
    vecs[8]  = '{32'h00000001, 32'h00000023, A_SHL,  32'h00000008, 32'h00000000};
    vecs[9]  = '{32'h00000001, 32'h00000001, A_ROR,  32'h80000000, 32'h00000000};
    vecs[10] = '{32'h80000001, 32'h00000001, A_ROL,  32'h00000003, 32'h00000000};
    vecs[11] = '{32'h12345678, 32'h00000020, A_ROL,  32'h12345678, 32'h00000000};
    vecs[12] = '{32'h00000000, 32'h00000005, A_NEG,  32'hFFFFFFFB, 32'h00000000};
    vecs[13] = '{32'h00000000, 32'h0F0F0F0F, A_NOT,  32'hF0F0F0F0, 32'h00000000};
    vecs[14] = '{32'h00000000, 32'hFFFFFFFF, A_INC,  32'h00000000, 32'h00000000};
    vecs[15] = '{32'h00000000, 32'hDEADBEEF, A_PASS, 32'hDEADBEEF, 32'h00000000};
    vecs[16] = '{32'hFFFFFFF9, 32'h00000002, A_DIV,  32'hFFFFFFFD, 32'hFFFFFFFF};
    vecs[17] = '{32'h00000009, 32'h00000000, A_DIV,  32'hFFFFFFFF, 32'h00000009};
    vecs[18] = '{32'h7FFFFFFF, 32'h7FFFFFFF, A_MUL,  32'h00000001, 32'h3FFFFFFF};
    vecs[19] = '{32'h00000007, 32'hFFFFFFFE, A_DIV,  32'hFFFFFFFD, 32'h00000001};
    vecs[20] = '{32'hFFFFFFFF, 32'hFFFFFFFF, A_MUL,  32'h00000001, 32'h00000000};
    vecs[21] = '{32'h80000000, 32'hFFFFFFFF, A_DIV,  32'h80000000, 32'h00000000};
    vecs[22] = '{32'hFFFFFFFF, 32'h00000001, A_ADD,  32'h00000000, 32'h00000000};

    // Reset
    reset = 1'b0; uop_valid = 1'b0; uop_src = 4'd0; uop_rsrc = 4'd0; uop_rdst = 4'd0;
    uop_dst = 9'h000; uop_zin = 1'b0; uop_alu = 4'd0; uop_mem = 2'b00; ba_mode = 1'b0;
    inport_data = '0; mem_rdata = '0; mem_ack = 1'b0;
    #1;
    check("rst_ready", 32'(uop_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_outport", outport_data, 32'd0);
    peek(SRC_PC, 4'd0, v);  check("rst_pc", v, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Table-driven ALU / MUL / DIV vectors
    for (int i = 0; i < 23; i++) begin
      exp_q.push_back(vecs[i].exp_lo);
      exp_q.push_back(vecs[i].exp_hi);
      load_via_in(vecs[i].y, DST_Y, 4'd0);
      inport_data = vecs[i].b;
      @(posedge clk); #1;
      issue(SRC_IN, 4'd0, 4'd0, 9'h000, 1'b1, vecs[i].alu, 2'b00);
      wait_idle(n);
      if (vecs[i].alu == A_MUL || vecs[i].alu == A_DIV)
        check($sformatf("row%0d_busy_cycles", i), 32'(n), 32'd32);
      else
        check($sformatf("row%0d_busy_cycles", i), 32'(n), 32'd0);
      peek(SRC_ZLO, 4'd0, v); check($sformatf("row%0d_zlo", i), v, exp_q.pop_front());
      peek(SRC_ZHI, 4'd0, v); check($sformatf("row%0d_zhi", i), v, exp_q.pop_front());
    end

    // Multi-destination load in one micro-op
    load_via_in(32'h11223344, DST_HI | DST_LO | DST_PC, 4'd0);
    peek(SRC_HI, 4'd0, v); check("multi_hi", v, 32'h11223344);
    peek(SRC_LO, 4'd0, v); check("multi_lo", v, 32'h11223344);
    peek(SRC_PC, 4'd0, v); check("multi_pc", v, 32'h11223344);

    // Register transfer via IMM and ba_mode
    load_via_in(32'h00000007, DST_IR, 4'd0);
    issue(SRC_IMM, 4'd0, 4'd3, DST_REG, 1'b0, A_ADD, 2'b00);
    issue(SRC_REG, 4'd3, 4'd0, DST_Y, 1'b0, A_ADD, 2'b00);
    issue(SRC_ZERO, 4'd0, 4'd0, 9'h000, 1'b1, A_ADD, 2'b00);
    peek(SRC_ZLO, 4'd0, v); check("reg3_to_y", v, 32'h00000007);
    load_via_in(32'hABC40005, DST_IR, 4'd0);
    peek(SRC_IMM, 4'd0, v); check("imm_sext", v, 32'hFFFC0005);
    load_via_in(32'h00000005, DST_REG, 4'd0);
    ba_mode = 1'b1;
    peek(SRC_REG, 4'd0, v); check("ba_reg0_zero", v, 32'd0);
    peek(SRC_REG, 4'd3, v); check("ba_reg3", v, 32'h00000007);
    issue(SRC_REG, 4'd0, 4'd0, DST_Y, 1'b0, A_ADD, 2'b00);
    issue(SRC_ZERO, 4'd0, 4'd0, 9'h000, 1'b1, A_ADD, 2'b00);
    peek(SRC_ZLO, 4'd0, v); check("ba_y_zero", v, 32'd0);
    ba_mode = 1'b0;
    peek(SRC_REG, 4'd0, v); check("reg0_written", v, 32'h00000005);

    // Memory read with 3 wait cycles and a micro-op held during the stall
    load_via_in(32'hAAAA5555, DST_MDR, 4'd0);
    load_via_in(32'hFFFFF1F5, DST_MAR, 4'd0);
    issue(SRC_ZERO, 4'd0, 4'd0, 9'h000, 1'b0, A_ADD, 2'b01);
    uop_src = SRC_MDR; uop_rsrc = 4'd0; uop_rdst = 4'd0; uop_dst = DST_OUT;
    uop_zin = 1'b0; uop_alu = A_ADD; uop_mem = 2'b00; uop_valid = 1'b1;
    req_cycles = 0; addr_ok = 1'b1; early = 1'b0;
    while (mem_req && req_cycles < 50) begin
      req_cycles++;
      if (uop_ready) early = 1'b1;
      if (mem_addr !== 9'h1F5 || mem_we !== 1'b0) addr_ok = 1'b0;
      if (req_cycles == 4) begin
        mem_ack = 1'b1;
        mem_rdata = 32'h13579BDF;
      end
      @(posedge clk); #1;
      mem_ack = 1'b0;
    end
    check("rd_req_cycles", 32'(req_cycles), 32'd4);
    check("rd_addr_stable", 32'(addr_ok), 32'd1);
    check("rd_ready_in_stall", 32'(early), 32'd0);
    check("rd_held_not_taken", outport_data, 32'd0);
    check("rd_ready_after", 32'(uop_ready), 32'd1);
    @(posedge clk); #1;
    uop_valid = 1'b0;
    check("rd_held_taken", outport_data, 32'h13579BDF);
    peek(SRC_MDR, 4'd0, v); check("rd_mdr", v, 32'h13579BDF);

    // Memory write with ack on the first MEM cycle
    load_via_in(32'h0BADF00D, DST_MDR, 4'd0);
    load_via_in(32'h00000012, DST_MAR, 4'd0);
    issue(SRC_ZERO, 4'd0, 4'd0, 9'h000, 1'b0, A_ADD, 2'b10);
    check("wr_req", 32'(mem_req), 32'd1);
    check("wr_we", 32'(mem_we), 32'd1);
    check("wr_addr", 32'(mem_addr), 32'h012);
    check("wr_wdata", mem_wdata, 32'h0BADF00D);
    mem_ack = 1'b1; mem_rdata = 32'h99999999;
    @(posedge clk); #1;
    check("wr_req_drop", 32'(mem_req), 32'd0);
    check("wr_ready", 32'(uop_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 mem_ack = 1'b0;
    peek(SRC_MDR, 4'd0, v); check("ack_idle_ignored", v, 32'h0BADF00D);
    check("ack_idle_state", 32'(state_dbg), 32'd0);

    // Reset in the middle of a MUL
    load_via_in(32'hFFFFFFFD, DST_Y, 4'd0);
    inport_data = 32'h00000007;
    @(posedge clk); #1;
    issue(SRC_IN, 4'd0, 4'd0, 9'h000, 1'b1, A_ADD, 2'b00);
    peek(SRC_ZLO, 4'd0, v); check("pre_mul_zlo", v, 32'h00000004);
    issue(SRC_IN, 4'd0, 4'd0, 9'h000, 1'b1, A_MUL, 2'b00);
    repeat (5) @(posedge clk);
    #1 check("mid_mul_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("rst_mul_busy", 32'(busy), 32'd0);
    check("rst_mul_ready", 32'(uop_ready), 32'd1);
    peek(SRC_ZLO, 4'd0, v); check("rst_mul_zlo", v, 32'd0);
    peek(SRC_ZHI, 4'd0, v); check("rst_mul_zhi", v, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (40) @(posedge clk);
    #1 check("post_rst_busy", 32'(busy), 32'd0);
    peek(SRC_ZLO, 4'd0, v); check("post_rst_zlo", v, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/param_bus_datapath.md
Name: param_bus_datapath

Overview:
Parametrised single-bus processor datapath. It holds the register file, HI/LO, Y, Z, PC, IR, MAR, MDR and in/out ports, plus a shared bus mux and an ALU. It is driven one micro-op per transaction by the control unit over a valid/ready handshake. Beyond the fixed 32-bit/16-register generation it adds:
- configurable width and register count;
- a stalling memory handshake;
- multi-cycle signed multiply/divide.

Parameters:
DATA_W, 32, datapath and register width (8..64, even)
NUM_REGS, 16, general registers (power of 2, 2..32); RIDX_W = log2(NUM_REGS)
ADDR_W, 9, memory address width (MAR low ADDR_W bits drive mem_addr)
IMM_W, 19, immediate field width in IR[IMM_W-1:0], sign-extended to DATA_W

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
uop_valid  in  1  micro-op present
uop_ready  out  1  datapath can accept a micro-op
uop_src  in  4  bus source: 0 REG[rsrc], 1 HI, 2 LO, 3 ZHI, 4 ZLO, 5 PC, 6 MDR, 7 INPORT, 8 IMM, 9-15 zero
uop_rsrc  in  RIDX_W  register read index
uop_rdst  in  RIDX_W  register write index
uop_dst  in  9  load mask: [0]REG[rdst] [1]Y [2]HI [3]LO [4]PC [5]MAR [6]MDR [7]IR [8]OUTPORT
uop_zin  in  1  load ALU result into ZHI/ZLO
uop_alu  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHR, 5 SHRA, 6 SHL, 7 ROR, 8 ROL, 9 NEG, 10 NOT, 11 INC (bus+1), 12 MUL, 13 DIV, 14-15 pass bus
uop_mem  in  2  00 none, 01 read, 10 write, 11 treated as none
ba_mode  in  1  REG[0] reads as zero on the bus
inport_data  in  DATA_W  external input, sampled every cycle into INPORT
mem_req  out  1  memory request
mem_we  out  1  write request
mem_addr  out  ADDR_W  MAR[ADDR_W-1:0]
mem_wdata  out  DATA_W  MDR
mem_rdata  in  DATA_W  read data
mem_ack  in  1  memory completion
outport_data  out  DATA_W  OUTPORT register
bus_dbg  out  DATA_W  current bus value
busy  out  1  not IDLE

Behaviour:
States:
- IDLE: uop_ready=1.
- MEM: waiting for mem_ack.
- MULDIV: iterating.

Reset (reset=0, asynchronous):
- All registers cleared, state IDLE.
- Outputs: mem_req=0, mem_we=0, busy=0, outport_data=0, uop_ready=1.
- Reset in MEM or MULDIV aborts the operation and discards partial results.

Acceptance = uop_valid & uop_ready at the rising edge. uop_ready depends on state only, never on uop_valid.

Bus:
- Combinational mux of uop_src.
- IMM = sign-extended IR[IMM_W-1:0].
- REG source with rsrc=0 and ba_mode=1 gives 0; writes to REG[0] are always honoured.

Single-cycle micro-op (uop_mem=00, alu not MUL/DIV):
- On acceptance, every register set in uop_dst loads the bus.
- If uop_zin: ZLO <= ALU(Y, bus) and ZHI <= 0; Y is the old Y value.
- Latency 1; next micro-op may be accepted the following cycle.

Arithmetic rules:
- Arithmetic is modulo 2^DATA_W.
- Shift/rotate amount = bus[log2(DATA_W)-1:0], applied to Y.
- NEG/NOT/INC/pass operate on the bus.
- SUB = Y - bus.

MUL/DIV (uop_zin=1):
- uop_dst loads happen at acceptance; operands Y and bus are captured at acceptance.
- State goes to MULDIV for exactly DATA_W cycles, with uop_ready=0, then IDLE.
- Z is written on the final cycle.
- MUL: {ZHI,ZLO} = signed Y*bus, 2*DATA_W bits.
- DIV: ZLO = quotient, ZHI = remainder. Truncating signed; remainder takes the dividend's sign.
- Divide by zero: ZLO = all ones, ZHI = Y.
- MUL/DIV with uop_zin=0 behaves as pass.

Memory micro-op (uop_mem=01/10):
- uop_dst, uop_zin and uop_alu are ignored.
- The cycle after acceptance the block enters MEM: mem_req=1, mem_we=(write), address from MAR, wdata from MDR, all held stable until mem_ack.
- On the mem_ack edge: a read loads MDR <= mem_rdata; the block returns to IDLE and mem_req drops the next cycle.
- Minimum latency 2 cycles (ack on the first MEM cycle); no timeout.
- mem_ack outside MEM is ignored.

A micro-op presented while uop_ready=0 is not consumed; the control unit must hold it stable.

Test Plan:
- Reset mid-MUL: assert reset during MULDIV -> busy=0, uop_ready=1 and Z=0 immediately, with no clock edge.
- Register transfer: IMM=0x0007 into REG[3], then src REG[3] with dst Y -> Y=7; with ba_mode=1, src REG[0] with dst Y after REG[0]=5 -> Y=0.
- ALU: Y=0x0000000C, bus=5 with SUB -> ZLO=7, ZHI=0. ROL with Y=0x80000001, bus=1 -> ZLO=0x00000003.
- MUL: Y=-3, bus=7 -> uop_ready low for 32 cycles, then {ZHI,ZLO}=0xFFFFFFFF_FFFFFFEB.
- DIV: Y=-7, bus=2 -> ZLO=-3, ZHI=-1. Y=9, bus=0 -> ZLO=0xFFFFFFFF, ZHI=9.
- Memory read with 3 wait cycles: MAR=0x1F5 -> mem_req high 4 cycles with mem_addr=0x1F5; MDR equals mem_rdata at ack; a micro-op held during the stall is accepted only after return to IDLE.
